// File: rtl/goodness_phase_ctrl.sv
// goodness_phase_ctrl
// Per-sample sequencer for the forward-forward goodness path.
//
// Sequence for one sample:
//   1. Clear the goodness EMA in every core.
//   2. Run the programmed number of timesteps. For each timestep, launch all
//      cores together, wait for each core to report done, then wait a few
//      cycles so the EMA update has landed.
//   3. Scan the per-core goodness against the threshold. Issue one
//      potentiate or depress request for each core that needs it, using a
//      valid/ready handshake.
//   4. Pulse done.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle sample start (ignored while busy)
//   label_pos           1 = positive sample, 0 = negative (latched at start)
//   num_timesteps       timesteps per sample, 0 treated as 1 (latched at start)
//   threshold           goodness threshold (latched at start)
//   core_ts_done        per-core one-cycle "timestep finished" pulses
//   avg_mem_bus         per-core goodness, core c at [c*GOODNESS_WIDTH +: GOODNESS_WIDTH]
//   core_ts_start       one-cycle timestep launch to all cores
//   core_clear_goodness one-cycle EMA clear to all cores
//   upd_valid/ready     update request handshake
//   upd_core_idx        core targeted by the request
//   upd_sign            1 = potentiate, 0 = depress
//   upd_margin          signed goodness minus threshold
//   busy                high whenever the sequencer is not idle
//   done                one-cycle pulse when the sample is complete
module goodness_phase_ctrl #(
  parameter int CORE_NUM       = 4,
  parameter int GOODNESS_WIDTH = 20,
  parameter int TS_WIDTH       = 8,
  parameter int SETTLE_CYC     = 2,
  localparam int IDX_W         = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               label_pos,
  input  logic [TS_WIDTH-1:0]                num_timesteps,
  input  logic [GOODNESS_WIDTH-1:0]          threshold,
  input  logic [CORE_NUM-1:0]                core_ts_done,
  input  logic [CORE_NUM*GOODNESS_WIDTH-1:0] avg_mem_bus,
  output logic [CORE_NUM-1:0]                core_ts_start,
  output logic [CORE_NUM-1:0]                core_clear_goodness,
  output logic                               upd_valid,
  input  logic                               upd_ready,
  output logic [IDX_W-1:0]                   upd_core_idx,
  output logic                               upd_sign,
  output logic [GOODNESS_WIDTH:0]            upd_margin,
  output logic                               busy,
  output logic                               done
);

  localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(CORE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STEP,
    S_WAIT,
    S_SETTLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                    state_reg;
  logic                      label_reg;
  logic [TS_WIDTH-1:0]       num_ts_reg;
  logic [GOODNESS_WIDTH-1:0] thr_reg;
  logic [TS_WIDTH-1:0]       ts_cnt_reg;
  logic [SETTLE_W-1:0]       settle_cnt_reg;
  logic [CORE_NUM-1:0]       done_mask_reg;
  logic [IDX_W-1:0]          idx_reg;

  // Unpack the goodness bus into one entry per core.
  logic [GOODNESS_WIDTH-1:0] goodness [CORE_NUM];

  generate
    for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_slice
      assign goodness[gi] = avg_mem_bus[gi*GOODNESS_WIDTH +: GOODNESS_WIDTH];
    end
  endgenerate

  logic [CORE_NUM-1:0]       mask_next;
  logic [TS_WIDTH-1:0]       ts_last;
  logic [IDX_W-1:0]          load_idx;
  logic [GOODNESS_WIDTH-1:0] load_g;
  logic                      load_active;
  logic [GOODNESS_WIDTH:0]   load_margin;

  // load_* describes the core that is entered on the next edge.
  // That is core 0 when leaving SETTLE, otherwise idx+1.
  // Goodness is sampled only at that edge. It is not re-read while the
  // request waits for ready.
  always_comb begin
    mask_next   = done_mask_reg | core_ts_done;
    ts_last     = (num_ts_reg == '0) ? '0 : num_ts_reg - TS_WIDTH'(1);
    load_idx    = '0;
    if (state_reg == S_EVAL && idx_reg != IDX_LAST) begin
      load_idx = idx_reg + IDX_W'(1);
    end
    load_g      = goodness[load_idx];
    load_active = label_reg ? (load_g < thr_reg) : (load_g >= thr_reg);
    // Both operands are zero-extended, so the signed result cannot overflow.
    load_margin = {1'b0, load_g} - {1'b0, thr_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= S_IDLE;
      label_reg           <= 1'b0;
      num_ts_reg          <= '0;
      thr_reg             <= '0;
      ts_cnt_reg          <= '0;
      settle_cnt_reg      <= '0;
      done_mask_reg       <= '0;
      idx_reg             <= '0;
      core_ts_start       <= '0;
      core_clear_goodness <= '0;
      upd_valid           <= 1'b0;
      upd_core_idx        <= '0;
      upd_sign            <= 1'b0;
      upd_margin          <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      // Pulse outputs default low. Each one is raised only on the
      // transition into the state that owns it.
      core_clear_goodness <= '0;
      core_ts_start       <= '0;
      done                <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            label_reg           <= label_pos;
            num_ts_reg          <= num_timesteps;
            thr_reg             <= threshold;
            ts_cnt_reg          <= '0;
            core_clear_goodness <= '1;
            busy                <= 1'b1;
            state_reg           <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          core_ts_start <= '1;
          state_reg     <= S_STEP;
        end

        // Done pulses that arrive during the launch cycle are dropped here.
        S_STEP: begin
          done_mask_reg <= '0;
          state_reg     <= S_WAIT;
        end

        S_WAIT: begin
          done_mask_reg <= mask_next;
          if (&mask_next) begin
            settle_cnt_reg <= '0;
            state_reg      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            if (ts_cnt_reg == ts_last) begin
              idx_reg   <= '0;
              upd_valid <= load_active;
              if (load_active) begin
                upd_core_idx <= load_idx;
                upd_sign     <= label_reg;
                upd_margin   <= load_margin;
              end
              state_reg <= S_EVAL;
            end else begin
              ts_cnt_reg    <= ts_cnt_reg + TS_WIDTH'(1);
              core_ts_start <= '1;
              state_reg     <= S_STEP;
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
          end
        end

        // A pending request holds until the handshake.
        // Once upd_valid is low (either no request, or the cycle after an
        // accepted one), the next core is entered.
        S_EVAL: begin
          if (upd_valid) begin
            if (upd_ready) begin
              upd_valid <= 1'b0;
            end
          end else if (idx_reg == IDX_LAST) begin
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            idx_reg   <= load_idx;
            upd_valid <= load_active;
            if (load_active) begin
              upd_core_idx <= load_idx;
              upd_sign     <= label_reg;
              upd_margin   <= load_margin;
            end
          end
        end

        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_goodness_phase_ctrl.sv
// tb_goodness_phase_ctrl
// Directed bench for goodness_phase_ctrl.
// Expected values are hand-computed from the sequencing rules. Monitors on
// the falling edge count pulses, record handshakes and watch that request
// fields stay stable while valid waits for ready.
module tb_goodness_phase_ctrl;

  localparam int CN = 4;
  localparam int GW = 20;
  localparam int TW = 8;
  localparam int SC = 2;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             label_pos;
  logic [TW-1:0]    num_timesteps;
  logic [GW-1:0]    threshold;
  logic [CN-1:0]    core_ts_done;
  logic [CN*GW-1:0] avg_mem_bus;
  logic [CN-1:0]    core_ts_start;
  logic [CN-1:0]    core_clear_goodness;
  logic             upd_valid;
  logic             upd_ready;
  logic [IW-1:0]    upd_core_idx;
  logic             upd_sign;
  logic [GW:0]      upd_margin;
  logic             busy;
  logic             done;

  goodness_phase_ctrl #(
    .CORE_NUM(CN), .GOODNESS_WIDTH(GW), .TS_WIDTH(TW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .label_pos(label_pos),
    .num_timesteps(num_timesteps), .threshold(threshold),
    .core_ts_done(core_ts_done), .avg_mem_bus(avg_mem_bus),
    .core_ts_start(core_ts_start), .core_clear_goodness(core_clear_goodness),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_core_idx(upd_core_idx),
    .upd_sign(upd_sign), .upd_margin(upd_margin), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Falling-edge monitors (sample away from the active edge).
  int step_pulses = 0;
  int clear_pulses = 0;
  int done_pulses = 0;
  int bad_vec = 0;
  int hold_cyc = 0;
  int stab_err = 0;
  int hs_n = 0;
  int hs_idx [64];
  int hs_sign [64];
  int hs_margin [64];
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [IW-1:0] prev_idx = '0;
  logic          prev_sign = 1'b0;
  logic [GW:0]   prev_margin = '0;

  always @(negedge clk) begin
    if (core_ts_start != '0) step_pulses <= step_pulses + 1;
    if (core_clear_goodness != '0) clear_pulses <= clear_pulses + 1;
    if (done) done_pulses <= done_pulses + 1;
    if ((core_ts_start != '0 && core_ts_start != '1) ||
        (core_clear_goodness != '0 && core_clear_goodness != '1))
      bad_vec <= bad_vec + 1;
    if (upd_valid && !upd_ready) hold_cyc <= hold_cyc + 1;
    if (prev_v && !prev_r && rst_n &&
        (!upd_valid || upd_core_idx != prev_idx || upd_sign != prev_sign ||
         upd_margin != prev_margin))
      stab_err <= stab_err + 1;
    if (upd_valid && upd_ready && hs_n < 64) begin
      hs_idx[hs_n]    <= int'(upd_core_idx);
      hs_sign[hs_n]   <= int'(upd_sign);
      hs_margin[hs_n] <= int'($signed(upd_margin));
      hs_n            <= hs_n + 1;
    end
    prev_v      <= upd_valid;
    prev_r      <= upd_ready;
    prev_idx    <= upd_core_idx;
    prev_sign   <= upd_sign;
    prev_margin <= upd_margin;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      tick();
      n++;
    end
    check("done_seen", longint'(done), 1);
  endtask

  // Called in the STEP cycle. Core c pulses d[c] cycles after the launch.
  // Core 0 also sends one duplicate pulse when one fits inside the wait.
  task automatic do_timestep(input int d [4], input bit last, input bit poke_start);
    int maxd = 0;
    int gap;
    for (int c = 0; c < CN; c++) if (d[c] > maxd) maxd = d[c];
    for (int k = 1; k <= maxd; k++) begin
      tick();
      core_ts_done = '0;
      for (int c = 0; c < CN; c++) if (d[c] == k) core_ts_done[c] = 1'b1;
      if (k == d[0] + 1) core_ts_done[0] = 1'b1;
      start = poke_start && (k == 1);
    end
    tick();
    core_ts_done = '0;
    start = 1'b0;
    if (!last) begin
      gap = 1;
      while (core_ts_start != '1 && gap < 20) begin
        tick();
        gap++;
      end
      check("settle_gap", gap, SC + 1);
    end
  endtask

  // Cores answer every launch one cycle later.
  // Returns the start-to-done cycle count.
  task automatic run_auto(input bit lbl, input int nts, input int thr, input int lim,
                          output int lat);
    bit pend;
    label_pos     = lbl;
    num_timesteps = TW'(nts);
    threshold     = GW'(thr);
    start         = 1'b1;
    lat           = 0;
    while (lat < lim) begin
      pend = (core_ts_start == '1);
      tick();
      start = 1'b0;
      lat++;
      core_ts_done = pend ? '1 : '0;
      if (done) break;
    end
    core_ts_done = '0;
    check("auto_done_seen", longint'(done), 1);
  endtask

  initial begin
    int s0, c0, d0, h0, hc0, lat, n;
    rst_n         = 1'b1;
    start         = 1'b0;
    label_pos     = 1'b0;
    num_timesteps = '0;
    threshold     = '0;
    core_ts_done  = '0;
    avg_mem_bus   = {20'd99, 20'd150, 20'd100, 20'd50};
    upd_ready     = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_valid", longint'(upd_valid), 0);
    check("rst_step", longint'(core_ts_start), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // A: positive label, three timesteps, staggered done pulses
    s0 = step_pulses; c0 = clear_pulses; d0 = done_pulses; h0 = hs_n;
    label_pos = 1'b1; threshold = 20'd100; num_timesteps = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("A_clear", longint'(core_clear_goodness), 15);
    check("A_busy", longint'(busy), 1);
    tick();
    check("A_step", longint'(core_ts_start), 15);
    do_timestep('{1, 3, 5, 2}, 1'b0, 1'b1);
    do_timestep('{4, 2, 1, 3}, 1'b0, 1'b0);
    do_timestep('{5, 5, 3, 1}, 1'b1, 1'b0);
    wait_done(60);
    tick();
    check("A_steps", step_pulses - s0, 3);
    check("A_clears", clear_pulses - c0, 1);
    check("A_dones", done_pulses - d0, 1);
    check("A_nreq", hs_n - h0, 2);
    check("A_r0_idx", hs_idx[h0], 0);
    check("A_r0_sign", hs_sign[h0], 1);
    check("A_r0_margin", hs_margin[h0], -50);
    check("A_r1_idx", hs_idx[h0+1], 3);
    check("A_r1_sign", hs_sign[h0+1], 1);
    check("A_r1_margin", hs_margin[h0+1], -1);

    // B: negative label, num_timesteps=0, ready stalled 7 cycles, start in DONE
    s0 = step_pulses; c0 = clear_pulses; h0 = hs_n; hc0 = hold_cyc;
    label_pos = 1'b0; num_timesteps = 8'd0; upd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_timestep('{2, 1, 2, 1}, 1'b1, 1'b0);
    n = 0;
    while (!upd_valid && n < 20) begin
      tick();
      n++;
    end
    check("B_valid_seen", longint'(upd_valid), 1);
    for (int i = 0; i < 6; i++) tick();
    tick();
    upd_ready = 1'b1;
    wait_done(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("B_busy_after", longint'(busy), 0);
    tick();
    tick();
    check("B_steps", step_pulses - s0, 1);
    check("B_clears", clear_pulses - c0, 1);
    check("B_hold", hold_cyc - hc0, 7);
    check("B_stable", stab_err, 0);
    check("B_nreq", hs_n - h0, 2);
    check("B_r0_idx", hs_idx[h0], 1);
    check("B_r0_sign", hs_sign[h0], 0);
    check("B_r0_margin", hs_margin[h0], 0);
    check("B_r1_idx", hs_idx[h0+1], 2);
    check("B_r1_margin", hs_margin[h0+1], 50);

    // D: reset in the middle of WAIT
    d0 = done_pulses;
    label_pos = 1'b1; threshold = '0; num_timesteps = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("D_busy", longint'(busy), 0);
    check("D_step", longint'(core_ts_start), 0);
    check("D_clear", longint'(core_clear_goodness), 0);
    check("D_valid", longint'(upd_valid), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("D_no_done", done_pulses - d0, 0);
    check("D_idle", longint'(busy), 0);

    // C: latency with no active cores and one timestep
    h0 = hs_n;
    run_auto(1'b1, 1, 0, 50, lat);
    check("C_latency", lat, 1 + 1 + 1 + SC + CN + 1);
    tick();
    check("C_nreq", hs_n - h0, 0);

    // E: maximum timestep count
    s0 = step_pulses;
    run_auto(1'b1, 255, 0, 3000, lat);
    tick();
    check("E_steps", step_pulses - s0, 255);
    check("bad_vectors", bad_vec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
